seg7_scan_ctrl: RTL
===================

// Module: seg7_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for the 8-digit seven-segment display.
//  - Shares the common segment bus between per-digit code sources and the motion-indicator code.
//  - Sequences the anodes with a blank guard interval between digits to prevent ghosting.
//  - Decodes 5-bit display codes to active-low segment patterns.
// PARAMETERS
//  NUM_DIGITS   8           number of digits scanned (2..8)
//  REFRESH_CNT  49_999      DRIVE phase lasts REFRESH_CNT+1 clk per digit (2 kHz slot at 100 MHz)
//  GUARD_CNT    99          GUARD phase lasts GUARD_CNT+1 clk, all anodes off
//  SIMULATE     0           1: use REFRESH_CNT=9, GUARD_CNT=1 regardless of the above
// PORTS
//  clk          in   1             system clock; single clock domain
//  reset        in   1             asynchronous, active-low reset
//  digit_code   in   5*NUM_DIGITS  code for digit i in bits [5i+4:5i]
//  dp_in        in   NUM_DIGITS    decimal point request per digit, 1 = lit
//  blank_mask   in   NUM_DIGITS    1 = digit i is kept dark during its slot
//  motion_en    in   1             enable motion-indicator overlay
//  motion_sel   in   3             digit index replaced by the overlay
//  motion_code  in   5             motion-indicator code (0 = blank, 16..22 = single segment a..g)
//  an           out  NUM_DIGITS    anode enables, active-low, registered
//  seg          out  7             cathodes {g,f,e,d,c,b,a}, active-low, registered
//  dp           out  1             decimal point cathode, active-low, registered
//  digit_idx    out  3             index of the digit currently in its slot
//  frame_tick   out  1             one-clk pulse at the end of each full scan
// BEHAVIOUR
//  - Reset (reset=0, asynchronous): an=all 1, seg=7'h7F, dp=1, digit_idx=0, frame_tick=0, state=GUARD, counter=0.
//  - FSM states:
//    - GUARD: an all 1, seg=7'h7F, dp=1. Counts 0..GUARD_CNT.
//      At GUARD_CNT: capture code/dp/mask for digit_idx into holding regs; counter<=0; go to DRIVE.
//    - DRIVE: an[digit_idx]=0 unless captured mask=1 (then all 1); seg/dp from held regs. Counts 0..REFRESH_CNT.
//      At REFRESH_CNT: digit_idx <= (idx==NUM_DIGITS-1) ? 0 : idx+1; counter<=0; go to GUARD.
//  - The first anode is driven GUARD_CNT+1 clk after reset release (registered outputs update on the transition edge).
//  - frame_tick=1 for exactly the clk in which digit_idx wraps NUM_DIGITS-1 -> 0.
//  - Frame period is NUM_DIGITS*(REFRESH_CNT+GUARD_CNT+2) clk.
//  - Source select at capture: if motion_en && motion_sel==digit_idx, use motion_code with dp forced off;
//    motion_code 0 decodes as blank.
//    Otherwise use digit_code[idx] and dp_in[idx]. motion_sel >= NUM_DIGITS never matches.
//  - Inputs changing during DRIVE have no effect until that digit's next capture. No mid-slot glitches.
//  - Decode (active-low, seg[0]=a):
//    - Codes 0..15: standard hex glyphs 0-9, A, b, C, d, E, F (e.g. 8 -> 7'b0000000, 1 -> 7'b1111001).
//    - Codes 16..22: light only segment (code-16), e.g. 16 -> 7'b1111110.
//    - Codes 23..31: blank (7'h7F).
//  - Counter width is $clog2(max(REFRESH_CNT,GUARD_CNT)+1); counter never exceeds its terminal value.
//  - Reset asserted mid-DRIVE: outputs go dark in the same instant (async) and the scan restarts at digit 0 in GUARD.
// TESTING (SIMULATE=1, NUM_DIGITS=8: slot = 10 DRIVE + 2 GUARD clk)
//  1. Hold reset=0 for 5 clk -> an=8'hFF, seg=7'h7F, dp=1.
//     Release -> an=8'hFE first appears 2 clk later and stays 10 clk.
//  2. digit_code = codes 0..7, mask=0 -> an steps FE,FD,FB,...,7F with 2 clk of FF between each;
//     frame_tick pulses every 96 clk.
//  3. Decode checks on digit 0:
//     - code 8 -> seg=7'b0000000
//     - code 16 -> 7'b1111110
//     - code 25 -> 7'h7F
//     - dp_in[0]=1 -> dp=0 during its slot
//  4. motion_en=1, sel=3, code=19, digit_code[3]=5 -> digit 3 shows seg=7'b1110111 with dp=1.
//     Set motion_code=0 -> digit 3 blank. sel=7 with en=0 -> digit 7 shows its own code.
//  5. blank_mask=8'h04 -> an never equals 8'hFB; slot timing of other digits unchanged.
//     Change digit_code[0] mid-DRIVE -> seg holds the old glyph until the next frame.
//  6. Assert reset during DRIVE of digit 5 -> an=8'hFF immediately, digit_idx=0.
//     After release the scan resumes at digit 0 with correct timing.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
`timescale 1ns/1ps
// Purpose: time-multiplexed 8-digit seven-segment scan controller with blank guard between digits.
// Latency: a captured code reaches seg/an on the GUARD->DRIVE edge; first anode GUARD_CNT+1 clk after reset.
// Backpressure: none; free-running scan. Inputs are sampled once per digit slot at capture.
//
// Ports:
//   clk, reset (async, active-low)
//   digit_code[5i+4:5i], dp_in[i], blank_mask[i] : per-digit code, decimal point, dark-slot request
//   motion_en/motion_sel/motion_code             : overlay replacing one digit's code (dp forced off)
//   an (active-low anodes), seg {g..a} and dp    : active-low cathodes, all registered
//   digit_idx                                    : digit currently owning the slot
//   frame_tick                                   : one-clk pulse when digit_idx wraps to 0
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_CNT = 49_999,
    parameter int GUARD_CNT   = 99,
    parameter int SIMULATE    = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [5*NUM_DIGITS-1:0] digit_code,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic                    motion_en,
    input  logic [2:0]              motion_sel,
    input  logic [4:0]              motion_code,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [2:0]              digit_idx,
    output logic                    frame_tick
);

    localparam int R_CNT = (SIMULATE != 0) ? 9 : REFRESH_CNT;
    localparam int G_CNT = (SIMULATE != 0) ? 1 : GUARD_CNT;
    localparam int MAX_CNT = (R_CNT > G_CNT) ? R_CNT : G_CNT;
    localparam int CW = (MAX_CNT > 0) ? $clog2(MAX_CNT + 1) : 1;

    localparam logic [CW-1:0]         R_TERM = CW'(R_CNT);
    localparam logic [CW-1:0]         G_TERM = CW'(G_CNT);
    localparam logic [2:0]            LAST   = 3'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_ONE = NUM_DIGITS'(1);

    typedef enum logic {
        S_GUARD = 1'b0,
        S_DRIVE = 1'b1
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    // Source selection for the digit about to be captured.
    logic       use_motion;
    logic [4:0] cur_code;
    logic       cur_dp;
    logic       cur_mask;
    logic [6:0] cur_seg;

    // Active-low glyphs, seg[0] = a.
    function automatic logic [6:0] seg_decode(input logic [4:0] code);
        logic [6:0] s;
        case (code)
            5'd0:  s = 7'b1000000;
            5'd1:  s = 7'b1111001;
            5'd2:  s = 7'b0100100;
            5'd3:  s = 7'b0110000;
            5'd4:  s = 7'b0011001;
            5'd5:  s = 7'b0010010;
            5'd6:  s = 7'b0000010;
            5'd7:  s = 7'b1111000;
            5'd8:  s = 7'b0000000;
            5'd9:  s = 7'b0010000;
            5'd10: s = 7'b0001000;
            5'd11: s = 7'b0000011;
            5'd12: s = 7'b1000110;
            5'd13: s = 7'b0100001;
            5'd14: s = 7'b0000110;
            5'd15: s = 7'b0001110;
            5'd16: s = 7'b1111110;
            5'd17: s = 7'b1111101;
            5'd18: s = 7'b1111011;
            5'd19: s = 7'b1110111;
            5'd20: s = 7'b1101111;
            5'd21: s = 7'b1011111;
            5'd22: s = 7'b0111111;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    always_comb begin
        // motion_sel values beyond the last digit can never equal digit_idx.
        use_motion = motion_en && (motion_sel == digit_idx);
        cur_code   = use_motion ? motion_code : digit_code[5*digit_idx +: 5];
        cur_dp     = use_motion ? 1'b0 : dp_in[digit_idx];
        cur_mask   = blank_mask[digit_idx];
        // Overlay code 0 means "no indicator", not the glyph '0'.
        cur_seg    = (use_motion && (motion_code == 5'd0)) ? 7'h7F : seg_decode(cur_code);
    end

    // The registered an/seg/dp double as the per-slot holding registers: they
    // are loaded only at capture and cleared only when the slot ends, so input
    // changes during DRIVE cannot disturb the lit digit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_GUARD;
            cnt        <= '0;
            digit_idx  <= '0;
            an         <= '1;
            seg        <= 7'h7F;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= 1'b0;
            case (state)
                S_GUARD: begin
                    if (cnt == G_TERM) begin
                        cnt   <= '0;
                        state <= S_DRIVE;
                        an    <= cur_mask ? '1 : ~(AN_ONE << digit_idx);
                        seg   <= cur_seg;
                        dp    <= ~cur_dp;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DRIVE: begin
                    if (cnt == R_TERM) begin
                        cnt        <= '0;
                        state      <= S_GUARD;
                        an         <= '1;
                        seg        <= 7'h7F;
                        dp         <= 1'b1;
                        frame_tick <= (digit_idx == LAST);
                        digit_idx  <= (digit_idx == LAST) ? 3'd0 : digit_idx + 3'd1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_GUARD;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
